multicycle_control_unit: RTL and testbench

//  Sequenced successor of the single-cycle opcode decoder: a multi-cycle FSM that steps each

---
 rtl/multicycle_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: steps each opcode through FETCH/DECODE/EXEC/MEM/WB,
// owns the imem/dmem req/ack handshakes and issues per-state datapath control pulses.
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 5,
  parameter int ALU_FUNC_W   = 3,
  parameter int TIMEOUT      = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_z,
  input  logic                    flag_l,
  input  logic                    flag_g,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dm_write_enable,
  output logic                    ir_write,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    reg_write,
  output logic                    is_move,
  output logic                    is_imm,
  output logic                    is_mem_access,
  output logic [ALU_FUNC_W-1:0]   alu_function,
  output logic                    flags_write,
  output logic                    halted,
  output logic                    bus_error,
  output logic [CNT_WIDTH-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic [4:0] op_lo;
  logic       op_ok;
  logic       dec_nop, dec_mov, dec_movi, dec_load, dec_store;
  logic       dec_alu, dec_jump, dec_halt, dec_illegal, jump_taken;

  assign op_lo = opcode[4:0];
  // Any opcode bit above [4:0] marks the instruction illegal.
  assign op_ok = ~|(opcode >> 5);

  always_comb begin
    dec_nop     = op_ok && (op_lo == 5'h00);
    dec_mov     = op_ok && (op_lo == 5'h01);
    dec_movi    = op_ok && (op_lo == 5'h02);
    dec_load    = op_ok && (op_lo == 5'h03);
    dec_store   = op_ok && (op_lo == 5'h04);
    dec_alu     = op_ok && (op_lo[4:3] == 2'b01 || op_lo[4:3] == 2'b10);
    dec_jump    = op_ok && (op_lo >= 5'h18) && (op_lo <= 5'h1C);
    dec_halt    = op_ok && (op_lo == 5'h1F);
    dec_illegal = !(dec_nop || dec_mov || dec_movi || dec_load || dec_store ||
                    dec_alu || dec_jump || dec_halt);
    case (op_lo)
      5'h18:   jump_taken = 1'b1;
      5'h19:   jump_taken = flag_z;
      5'h1A:   jump_taken = !flag_z;
      5'h1B:   jump_taken = flag_l;
      5'h1C:   jump_taken = flag_g;
      default: jump_taken = 1'b0;
    endcase
  end

  // Mux controls follow the IR opcode while an instruction is in flight (DECODE..WB).
  logic in_flight;
  assign in_flight     = (state == S_DECODE) || (state == S_EXEC) ||
                         (state == S_MEM)    || (state == S_WB);
  assign is_move       = in_flight && (dec_mov || dec_movi);
  assign is_imm        = in_flight && (dec_movi || (dec_alu && op_lo[4]));
  assign is_mem_access = in_flight && (dec_load || dec_store);
  assign alu_function  = (in_flight && dec_alu) ? ALU_FUNC_W'(op_lo[2:0]) : '0;

  // IR latch and PC increment coincide with the accepting imem edge.
  assign ir_write = (state == S_FETCH) && imem_req && imem_ack;
  assign pc_inc   = ir_write;
  assign pc_load  = (state == S_EXEC) && dec_jump && jump_taken;

  logic bus_req, bus_ack, timed_out;
  assign bus_req   = imem_req || dmem_req;
  assign bus_ack   = (imem_req && imem_ack) || (dmem_req && dmem_ack);
  assign timed_out = bus_req && !bus_ack && (wait_cnt == TMO_LAST);

  // NOTE: async reset clears every state bit, including in-flight requests; all
  // state updates use non-blocking assignments so the block reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_FETCH;
      wait_cnt        <= '0;
      imem_req        <= 1'b0;
      dmem_req        <= 1'b0;
      dm_write_enable <= 1'b0;
      reg_write       <= 1'b0;
      flags_write     <= 1'b0;
      halted          <= 1'b0;
      bus_error       <= 1'b0;
      retired         <= '0;
    end else begin
      // NOTE: pulses default low here so every branch below only raises them.
      reg_write   <= 1'b0;
      flags_write <= 1'b0;
      wait_cnt    <= (bus_req && !bus_ack && !timed_out) ? wait_cnt + 8'd1 : '0;

      if (timed_out) begin
        state           <= S_HALT;
        imem_req        <= 1'b0;
        dmem_req        <= 1'b0;
        dm_write_enable <= 1'b0;
        bus_error       <= 1'b1;
        halted          <= 1'b1;
      end else begin
        case (state)
          S_FETCH: begin
            if (!imem_req) begin
              imem_req <= 1'b1;
            end else if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (dec_illegal) begin
              bus_error <= 1'b1;
              halted    <= 1'b1;
              state     <= S_HALT;
            end else if (dec_halt) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              flags_write <= dec_alu;
              state       <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (dec_alu || dec_mov || dec_movi) begin
              reg_write <= 1'b1;
              state     <= S_WB;
            end else if (dec_load || dec_store) begin
              dmem_req        <= 1'b1;
              dm_write_enable <= dec_store;
              state           <= S_MEM;
            end else begin
              imem_req <= 1'b1;
              retired  <= retired + CNT_WIDTH'(1);
              state    <= S_FETCH;
            end
          end
          S_MEM: begin
            if (dmem_ack) begin
              dmem_req        <= 1'b0;
              dm_write_enable <= 1'b0;
              if (dec_load) begin
                reg_write <= 1'b1;
                state     <= S_WB;
              end else begin
                imem_req <= 1'b1;
                retired  <= retired + CNT_WIDTH'(1);
                state    <= S_FETCH;
              end
            end
          end
          S_WB: begin
            imem_req <= 1'b1;
            retired  <= retired + CNT_WIDTH'(1);
            state    <= S_FETCH;
          end
          default: ;  // S_HALT is absorbing
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default instance plus a 6-bit-opcode,
// 2-bit-counter instance for wide-opcode legality and retired wrap-around.
module tb_multicycle_control_unit;

  logic clk, rst_n;
  logic [4:0] opcode;
  logic flag_z, flag_l, flag_g, imem_ack, dmem_ack;
  logic imem_req, dmem_req, dm_write_enable, ir_write, pc_inc, pc_load, reg_write;
  logic is_move, is_imm, is_mem_access, flags_write, halted, bus_error;
  logic [2:0]  alu_function;
  logic [15:0] retired;

  logic [5:0] u2_opcode;
  logic u2_imem_ack;
  logic u2_imem_req, u2_dmem_req, u2_dm_write_enable, u2_ir_write, u2_pc_inc, u2_pc_load;
  logic u2_reg_write, u2_is_move, u2_is_imm, u2_is_mem_access, u2_flags_write;
  logic u2_halted, u2_bus_error;
  logic [2:0] u2_alu_function;
  logic [1:0] u2_retired;

  int checks = 0;
  int fails  = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .flag_z(flag_z), .flag_l(flag_l), .flag_g(flag_g),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dm_write_enable(dm_write_enable),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write),
    .is_move(is_move), .is_imm(is_imm), .is_mem_access(is_mem_access),
    .alu_function(alu_function), .flags_write(flags_write),
    .halted(halted), .bus_error(bus_error), .retired(retired)
  );

  multicycle_control_unit #(.OPCODE_WIDTH(6), .CNT_WIDTH(2)) dut_w6 (
    .clk(clk), .rst_n(rst_n), .opcode(u2_opcode),
    .flag_z(1'b0), .flag_l(1'b0), .flag_g(1'b0),
    .imem_ack(u2_imem_ack), .dmem_ack(1'b0),
    .imem_req(u2_imem_req), .dmem_req(u2_dmem_req), .dm_write_enable(u2_dm_write_enable),
    .ir_write(u2_ir_write), .pc_inc(u2_pc_inc), .pc_load(u2_pc_load), .reg_write(u2_reg_write),
    .is_move(u2_is_move), .is_imm(u2_is_imm), .is_mem_access(u2_is_mem_access),
    .alu_function(u2_alu_function), .flags_write(u2_flags_write),
    .halted(u2_halted), .bus_error(u2_bus_error), .retired(u2_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUTs at the start of a FETCH cycle with imem_req already high.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Per-instruction observations gathered by run_instr.
  int m_total, m_req, m_rw, m_fw, m_pl, m_we, m_both, m_rw_at, m_last_req;
  logic [2:0] m_mux, m_alu;

  // Runs one instruction from the start of FETCH; dmem acks after dwait wait cycles.
  task automatic run_instr(input logic [4:0] op, input int dwait);
    opcode = op; imem_ack = 1'b1; dmem_ack = 1'b0;
    m_total = 0; m_req = 0; m_rw = 0; m_fw = 0; m_pl = 0; m_we = 0; m_both = 0;
    m_rw_at = 0; m_last_req = 0; m_mux = 3'bxxx; m_alu = 3'bxxx;
    for (int n = 1; n <= 40; n++) begin
      #1;
      m_total = n;
      if (n == 2) begin
        m_mux = {is_move, is_imm, is_mem_access};
        m_alu = alu_function;
      end
      if (dmem_req) begin
        m_req++;
        m_last_req = n;
        dmem_ack = (m_req == dwait + 1);
      end else begin
        dmem_ack = 1'b0;
      end
      if (reg_write) begin m_rw++; m_rw_at = n; end
      m_fw   += int'(flags_write);
      m_pl   += int'(pc_load);
      m_we   += int'(dm_write_enable);
      m_both += int'(pc_inc && pc_load);
      step();
      if (imem_req || halted) break;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({imem_req, dmem_req, dm_write_enable, ir_write, pc_inc, pc_load, reg_write} !== 7'd0) begin fails++; $display("FAIL reset_ctrl: got %b expected 0000000", {imem_req, dmem_req, dm_write_enable, ir_write, pc_inc, pc_load, reg_write}); end
    checks++; if ({is_move, is_imm, is_mem_access, flags_write, halted, bus_error, alu_function} !== 9'd0) begin fails++; $display("FAIL reset_misc: got %b expected 0", {is_move, is_imm, is_mem_access, flags_write, halted, bus_error, alu_function}); end
    checks++; if (retired !== 16'd0) begin fails++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_fetch_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_add();
    opcode = 5'h08; imem_ack = 1'b1; dmem_ack = 1'b0;
    #1;
    checks++; if ({ir_write, pc_inc} !== 2'b11) begin fails++; $display("FAIL add_fetch_pulses: got %b expected 11", {ir_write, pc_inc}); end
    step();  // DECODE
    checks++; if ({imem_req, flags_write, reg_write, is_imm, alu_function} !== 7'd0) begin fails++; $display("FAIL add_decode: got %b expected 0000000", {imem_req, flags_write, reg_write, is_imm, alu_function}); end
    step();  // EXEC
    checks++; if ({flags_write, reg_write} !== 2'b10) begin fails++; $display("FAIL add_exec: got %b expected 10", {flags_write, reg_write}); end
    step();  // WB
    checks++; if ({flags_write, reg_write} !== 2'b01) begin fails++; $display("FAIL add_wb: got %b expected 01", {flags_write, reg_write}); end
    checks++; if (retired !== 16'd0) begin fails++; $display("FAIL add_retired_wb: got %0d expected 0", retired); end
    step();  // next FETCH
    checks++; if ({imem_req, reg_write} !== 2'b10) begin fails++; $display("FAIL add_refetch: got %b expected 10", {imem_req, reg_write}); end
    checks++; if (retired !== 16'd1) begin fails++; $display("FAIL add_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_load_wait();
    run_instr(5'h03, 3);
    checks++; if (m_total !== 8) begin fails++; $display("FAIL load_total: got %0d expected 8", m_total); end
    checks++; if (m_req !== 4) begin fails++; $display("FAIL load_dmem_req_cycles: got %0d expected 4", m_req); end
    checks++; if (m_rw !== 1 || m_rw_at !== m_last_req + 1) begin fails++; $display("FAIL load_reg_write: got %0d at %0d expected 1 at 8", m_rw, m_rw_at); end
    checks++; if (m_we !== 0) begin fails++; $display("FAIL load_we: got %0d expected 0", m_we); end
  endtask

  typedef struct { logic [4:0] op; logic z, l, g; int pl; } jmp_t;
  jmp_t jmp_tab [8] = '{
    '{5'h19, 1'b1, 1'b0, 1'b0, 1}, '{5'h19, 1'b0, 1'b1, 1'b1, 0},
    '{5'h1A, 1'b0, 1'b0, 1'b0, 1}, '{5'h1A, 1'b1, 1'b0, 1'b0, 0},
    '{5'h1B, 1'b0, 1'b1, 1'b0, 1}, '{5'h1C, 1'b1, 1'b1, 1'b0, 0},
    '{5'h1C, 1'b0, 1'b0, 1'b1, 1}, '{5'h18, 1'b0, 1'b0, 1'b0, 1}
  };

  task automatic test_jumps();
    for (int i = 0; i < 8; i++) begin
      flag_z = jmp_tab[i].z; flag_l = jmp_tab[i].l; flag_g = jmp_tab[i].g;
      run_instr(jmp_tab[i].op, 0);
      checks++; if (m_pl !== jmp_tab[i].pl) begin fails++; $display("FAIL jump_pc_load[%0d]: got %0d expected %0d", i, m_pl, jmp_tab[i].pl); end
      checks++; if (m_total !== 3 || m_both !== 0) begin fails++; $display("FAIL jump_timing[%0d]: got %0d cycles %0d overlaps expected 3 and 0", i, m_total, m_both); end
    end
    flag_z = 1'b0; flag_l = 1'b0; flag_g = 1'b0;
  endtask

  typedef struct { logic [4:0] op; int dwait; int total; int rw; int fw; int we; logic [2:0] mux; logic [2:0] alu; } lat_t;
  lat_t lat_tab [8] = '{
    '{5'h00, 0, 3, 0, 0, 0, 3'b000, 3'd0}, '{5'h01, 0, 4, 1, 0, 0, 3'b100, 3'd0},
    '{5'h02, 0, 4, 1, 0, 0, 3'b110, 3'd0}, '{5'h03, 0, 5, 1, 0, 0, 3'b001, 3'd0},
    '{5'h04, 0, 4, 0, 0, 1, 3'b001, 3'd0}, '{5'h0D, 0, 4, 1, 1, 0, 3'b000, 3'd5},
    '{5'h15, 0, 4, 1, 1, 0, 3'b010, 3'd5}, '{5'h04, 2, 6, 0, 0, 3, 3'b001, 3'd0}
  };

  task automatic test_latency();
    for (int i = 0; i < 8; i++) begin
      run_instr(lat_tab[i].op, lat_tab[i].dwait);
      checks++; if (m_total !== lat_tab[i].total) begin fails++; $display("FAIL lat_total[%0d]: got %0d expected %0d", i, m_total, lat_tab[i].total); end
      checks++; if (m_rw !== lat_tab[i].rw || m_fw !== lat_tab[i].fw || m_we !== lat_tab[i].we) begin fails++; $display("FAIL lat_pulses[%0d]: got rw=%0d fw=%0d we=%0d expected rw=%0d fw=%0d we=%0d", i, m_rw, m_fw, m_we, lat_tab[i].rw, lat_tab[i].fw, lat_tab[i].we); end
      checks++; if (m_mux !== lat_tab[i].mux || m_alu !== lat_tab[i].alu) begin fails++; $display("FAIL lat_decode[%0d]: got mux=%b alu=%0d expected mux=%b alu=%0d", i, m_mux, m_alu, lat_tab[i].mux, lat_tab[i].alu); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] start;
    start = retired;
    run_instr(5'h0A, 0);
    run_instr(5'h00, 0);
    run_instr(5'h03, 1);
    checks++; if (retired !== start + 16'd3) begin fails++; $display("FAIL b2b_retired: got %0d expected %0d", retired, start + 16'd3); end
  endtask

  task automatic test_ack_on_last_cycle();
    opcode = 5'h00; imem_ack = 1'b0;
    repeat (14) step();
    checks++; if ({imem_req, halted} !== 2'b10) begin fails++; $display("FAIL ack_last_pre: got %b expected 10", {imem_req, halted}); end
    imem_ack = 1'b1;
    step();
    checks++; if ({imem_req, bus_error, halted} !== 3'b000) begin fails++; $display("FAIL ack_last_wins: got %b expected 000", {imem_req, bus_error, halted}); end
    step(); step();
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL ack_last_refetch: got %b expected 1", imem_req); end
  endtask

  task automatic test_timeout();
    logic [15:0] frozen;
    int req_cycles;
    frozen = retired; req_cycles = 0;
    opcode = 5'h00; imem_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) req_cycles++;
      if (halted) break;
      step();
    end
    checks++; if (req_cycles !== 15) begin fails++; $display("FAIL timeout_req_cycles: got %0d expected 15", req_cycles); end
    repeat (3) step();
    checks++; if ({imem_req, bus_error, halted} !== 3'b011) begin fails++; $display("FAIL timeout_state: got %b expected 011", {imem_req, bus_error, halted}); end
    checks++; if (retired !== frozen) begin fails++; $display("FAIL timeout_retired: got %0d expected %0d", retired, frozen); end
  endtask

  task automatic test_reset_mid_mem();
    checks++; if (retired === 16'd0) begin fails++; $display("FAIL mid_mem_precond: got retired 0 expected nonzero"); end
    opcode = 5'h03; imem_ack = 1'b1; dmem_ack = 1'b0;
    step(); step(); step();
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL mid_mem_req: got %b expected 1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dmem_req, imem_req, halted} !== 3'b000 || retired !== 16'd0) begin fails++; $display("FAIL mid_mem_async: got req=%b retired=%0d expected 0 and 0", dmem_req, retired); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if ({imem_req, dmem_req} !== 2'b10 || retired !== 16'd0) begin fails++; $display("FAIL mid_mem_release: got req=%b retired=%0d expected 10 and 0", {imem_req, dmem_req}, retired); end
  endtask

  task automatic test_illegal();
    logic [4:0] bad [2] = '{5'h05, 5'h1E};
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      opcode = bad[i]; imem_ack = 1'b1;
      step(); step();
      checks++; if ({halted, bus_error, reg_write} !== 3'b110) begin fails++; $display("FAIL illegal_halt[%0d]: got %b expected 110", i, {halted, bus_error, reg_write}); end
      step();
      checks++; if ({imem_req, reg_write} !== 2'b00 || retired !== 16'd0) begin fails++; $display("FAIL illegal_quiet[%0d]: got req/rw=%b retired=%0d expected 00 and 0", i, {imem_req, reg_write}, retired); end
    end
  endtask

  task automatic test_halt_op();
    apply_reset();
    opcode = 5'h1F; imem_ack = 1'b1;
    step(); step();
    checks++; if ({halted, bus_error} !== 2'b10) begin fails++; $display("FAIL halt_op: got %b expected 10", {halted, bus_error}); end
    repeat (3) step();
    checks++; if ({halted, imem_req, retired} !== {2'b10, 16'd0}) begin fails++; $display("FAIL halt_absorbing: got halted=%b req=%b retired=%0d expected 1 0 0", halted, imem_req, retired); end
  endtask

  task automatic test_wrap_and_wide_opcode();
    apply_reset();
    u2_opcode = 6'h00; u2_imem_ack = 1'b1;
    repeat (9) step();
    checks++; if (u2_retired !== 2'b11 || u2_imem_req !== 1'b1) begin fails++; $display("FAIL wrap_all_ones: got %0d expected 3", u2_retired); end
    repeat (3) step();
    checks++; if (u2_retired !== 2'b00) begin fails++; $display("FAIL wrap_zero: got %0d expected 0", u2_retired); end
    u2_opcode = 6'h28;
    step(); step();
    checks++; if ({u2_halted, u2_bus_error, u2_reg_write} !== 3'b110) begin fails++; $display("FAIL wide_illegal: got %b expected 110", {u2_halted, u2_bus_error, u2_reg_write}); end
    checks++; if (u2_retired !== 2'b00) begin fails++; $display("FAIL wide_illegal_retired: got %0d expected 0", u2_retired); end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 5'h00; flag_z = 1'b0; flag_l = 1'b0; flag_g = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; u2_opcode = 6'h00; u2_imem_ack = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_jumps();
    test_latency();
    test_back_to_back();
    test_ack_on_last_cycle();
    test_reset_mid_mem();
    test_timeout();
    test_illegal();
    test_halt_op();
    test_wrap_and_wide_opcode();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
